fft_bin_streamer: RTL and testbench

Producer end of the FFT-bin interface consumed by main_fsm. Captures one frame of complex FFT output bins from the FFT core into a ping-pong (two-bank) buffer. Replays each complete frame to main_fsm as a contiguous burst on fft_done/fft_address/fft_read_valid/data_in_real/data_in_imag. Waits for main_fsm's note_done before starting the next burst.

---
 rtl/fft_bin_streamer_pkg.sv | 15 +
 rtl/fft_bin_streamer_if.sv | 36 +++
 rtl/fft_bin_bank_ram.sv | 34 +++
 rtl/fft_bin_streamer.sv | 157 +++++++++++++++
 tb/tb_fft_bin_streamer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_bin_streamer_pkg.sv
// Shared sizing constants and read-FSM state encoding for the FFT bin streamer.
package fft_stream_pkg;

  localparam int N_BINS = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 18;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t ST_IDLE     = 2'd0;
  localparam rd_state_t ST_PREFETCH = 2'd1;
  localparam rd_state_t ST_STREAM   = 2'd2;
  localparam rd_state_t ST_WAIT_ACK = 2'd3;

endpackage

// File: rtl/fft_bin_streamer_if.sv
// Bin capture input from the FFT core and burst output towards main_fsm.
interface fft_bin_streamer_if
  import fft_stream_pkg::*;
#(
  parameter int ADDR_W = fft_stream_pkg::ADDR_W,
  parameter int DATA_W = fft_stream_pkg::DATA_W
);

  logic                     in_valid;
  logic [ADDR_W-1:0]        in_index;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     note_done;
  logic                     fft_done;
  logic                     fft_read_valid;
  logic [ADDR_W-1:0]        fft_address;
  logic signed [DATA_W-1:0] data_in_real;
  logic signed [DATA_W-1:0] data_in_imag;
  logic                     frame_dropped;
  logic                     seq_error;

  // The streamer side: takes bins and acknowledges, drives the burst.
  modport master (
    input  in_valid, in_index, in_real, in_imag, note_done,
    output fft_done, fft_read_valid, fft_address, data_in_real, data_in_imag,
           frame_dropped, seq_error
  );

  // The environment side: FFT core plus the consuming note detector.
  modport slave (
    output in_valid, in_index, in_real, in_imag, note_done,
    input  fft_done, fft_read_valid, fft_address, data_in_real, data_in_imag,
           frame_dropped, seq_error
  );

endinterface

// File: rtl/fft_bin_bank_ram.sv
// Two-bank bin store: simple dual-port RAM addressed as {bank, index},
// one write port for capture and a registered read port (latency 1).
module fft_bin_bank_ram
  import fft_stream_pkg::*;
#(
  parameter int ADDR_W = fft_stream_pkg::ADDR_W,
  parameter int DATA_W = fft_stream_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ADDR_W:0]     waddr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  input  logic [ADDR_W:0]     raddr_i,
  output logic [2*DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] rdata_q;

  // Capture-side write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Synchronous read, data available the cycle after the address.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bin_streamer.sv
// Captures FFT frames into a ping-pong bin buffer and replays each complete
// frame to main_fsm as one contiguous burst, waiting for note_done between bursts.
module fft_bin_streamer
  import fft_stream_pkg::*;
#(
  parameter int N_BINS = fft_stream_pkg::N_BINS,
  parameter int ADDR_W = fft_stream_pkg::ADDR_W,
  parameter int DATA_W = fft_stream_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  fft_bin_streamer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BINS - 1);

  // Capture-side state
  logic [ADDR_W-1:0] exp_idx_q, exp_idx_d;
  logic              drop_q, drop_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              cap_v, frame_start, idx_bad, drop_eff, frame_end;
  logic              wr_en, set_full;

  // Read-side state
  rd_state_t                state_q, state_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]        out_addr_q, out_addr_d;
  logic signed [DATA_W-1:0] re_q, re_d;
  logic signed [DATA_W-1:0] im_q, im_d;
  logic                     clr_full;
  logic [ADDR_W:0]          raddr;
  logic [2*DATA_W-1:0]      rdata;

  // Capture decode: an index-0 bin opens a frame and decides its fate from the
  // target bank's fullness; any out-of-order bin poisons the rest of the frame.
  always_comb begin
    cap_v       = bus.in_valid && !reset;
    frame_start = cap_v && (bus.in_index == '0);
    idx_bad     = cap_v && (bus.in_index != exp_idx_q);
    drop_eff    = frame_start ? bank_full_q[wr_bank_q] : (drop_q || idx_bad);
    frame_end   = cap_v && (bus.in_index == LAST_IDX);
    wr_en       = cap_v && !drop_eff;
    set_full    = frame_end && !drop_eff;
    exp_idx_d   = exp_idx_q;
    drop_d      = drop_q;
    wr_bank_d   = wr_bank_q;
    if (cap_v) begin
      exp_idx_d = bus.in_index + 1'b1;
      drop_d    = drop_eff;
    end
    if (set_full) wr_bank_d = ~wr_bank_q;
  end

  // Bank occupancy: a finished capture sets its bank, a finished burst clears
  // its bank; the clear is applied last so it wins on the same bank.
  always_comb begin
    bank_full_d = bank_full_q;
    if (set_full) bank_full_d[wr_bank_q] = 1'b1;
    if (clr_full) bank_full_d[rd_bank_q] = 1'b0;
  end

  // Read FSM: the RAM address runs one bin ahead of the presented address so
  // the registered data lines up with fft_address.
  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    out_addr_d = out_addr_q;
    re_d       = '0;
    im_d       = '0;
    clr_full   = 1'b0;
    raddr      = {rd_bank_q, rd_ptr_q};
    case (state_q)
      ST_IDLE: begin
        raddr = {rd_bank_q, {ADDR_W{1'b0}}};
        if (bank_full_q[rd_bank_q]) begin
          state_d  = ST_PREFETCH;
          rd_ptr_d = ADDR_W'(1);
        end
      end
      ST_PREFETCH: begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        out_addr_d = '0;
        re_d       = $signed(rdata[2*DATA_W-1:DATA_W]);
        im_d       = $signed(rdata[DATA_W-1:0]);
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (out_addr_q == LAST_IDX) begin
          out_addr_d = '0;
          clr_full   = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          state_d    = ST_WAIT_ACK;
        end else begin
          out_addr_d = out_addr_q + 1'b1;
          re_d       = $signed(rdata[2*DATA_W-1:DATA_W]);
          im_d       = $signed(rdata[DATA_W-1:0]);
        end
      end
      ST_WAIT_ACK: begin
        if (bus.note_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset empties both banks and aborts any burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_idx_q   <= '0;
      drop_q      <= 1'b0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      state_q     <= ST_IDLE;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      out_addr_q  <= '0;
      re_q        <= '0;
      im_q        <= '0;
    end else begin
      exp_idx_q   <= exp_idx_d;
      drop_q      <= drop_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      out_addr_q  <= out_addr_d;
      re_q        <= re_d;
      im_q        <= im_d;
    end
  end

  fft_bin_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, bus.in_index}),
    .wdata_i ({bus.in_real, bus.in_imag}),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.fft_done       = (state_q == ST_STREAM);
  assign bus.fft_read_valid = (state_q == ST_STREAM);
  assign bus.fft_address    = out_addr_q;
  assign bus.data_in_real   = re_q;
  assign bus.data_in_imag   = im_q;
  assign bus.seq_error      = idx_bad;
  assign bus.frame_dropped  = frame_end && drop_eff;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Self-checking bench for fft_bin_streamer: a frame-level reference model
// (queue of captured frames, burst timeline) checked every cycle, plus
// literal latency/length/count checks for the directed scenarios.
module tb_fft_bin_streamer;

  localparam int NB = 512;
  localparam int AW = 9;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_bin_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fft_bin_streamer #(.N_BINS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [2*DW-1:0] full_q [$];
  logic [2*DW-1:0] cur [NB];
  int cap_exp     = 0;
  bit cap_drop    = 1'b0;
  int pos         = -1;
  int start_in    = 0;
  bit waiting_ack = 1'b0;

  // Observation counters
  bit prev_done      = 1'b0;
  int cur_len        = 0;
  int last_len       = 0;
  int bursts         = 0;
  int first_done_cyc = 0;
  int seq_cnt        = 0;
  int drop_cnt       = 0;
  bit lit_kk         = 1'b0;
  int last_wr_cyc    = 0;
  int ack_cyc        = 0;

  // Per-cycle compare against the model, then advance the model one cycle.
  always @(negedge clk) begin
    logic [AW+2*DW+3:0] exp_v, act_v;
    logic [2*DW-1:0]    exp_d;
    logic signed [DW-1:0] er, ei;
    int occ, idx;
    bit vin, start, bad, deff, was_idle;

    occ   = full_q.size() / NB;
    vin   = bus.in_valid && !reset;
    idx   = int'(bus.in_index);
    start = vin && (idx == 0);
    bad   = vin && (idx != cap_exp);
    deff  = start ? (occ == 2) : (cap_drop || bad);
    exp_d = (pos >= 0) ? full_q[pos] : '0;
    exp_v = {pos >= 0, pos >= 0, AW'(pos >= 0 ? pos : 0), exp_d, bad,
             vin && (idx == NB - 1) && deff};
    act_v = {bus.fft_done, bus.fft_read_valid, bus.fft_address, bus.data_in_real,
             bus.data_in_imag, bus.seq_error, bus.frame_dropped};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle cyc=%0d got=%h expected=%h", cyc, act_v, exp_v);
    end

    if (lit_kk && bus.fft_done) begin
      er = DW'(int'(bus.fft_address));
      ei = -er;
      checks++;
      if (bus.data_in_real !== er || bus.data_in_imag !== ei) begin
        errors++;
        $display("FAIL kk_data addr=%0d got re=%0d im=%0d want re=%0d im=%0d",
                 bus.fft_address, bus.data_in_real, bus.data_in_imag, er, ei);
      end
    end

    if (bus.fft_done && !prev_done) begin first_done_cyc = cyc; cur_len = 0; end
    if (bus.fft_done) cur_len++;
    if (!bus.fft_done && prev_done) begin last_len = cur_len; bursts++; end
    prev_done = bus.fft_done;
    if (bus.seq_error) seq_cnt++;
    if (bus.frame_dropped) drop_cnt++;

    if (reset) begin
      full_q.delete();
      cap_exp = 0; cap_drop = 1'b0; pos = -1; start_in = 0; waiting_ack = 1'b0;
    end else begin
      was_idle = (pos < 0) && (start_in == 0) && !waiting_ack;
      if (waiting_ack) begin
        if (bus.note_done) waiting_ack = 1'b0;
      end else if (pos == NB - 1) begin
        for (int i = 0; i < NB; i++) void'(full_q.pop_front());
        pos = -1;
        waiting_ack = 1'b1;
      end else if (pos >= 0) begin
        pos++;
      end
      if (was_idle && occ >= 1) start_in = 2;
      if (start_in > 0) begin
        start_in--;
        if (start_in == 0) pos = 0;
      end
      if (vin) begin
        if (!deff) cur[idx] = {bus.in_real, bus.in_imag};
        if (idx == NB - 1 && !deff)
          for (int i = 0; i < NB; i++) full_q.push_back(cur[i]);
        cap_exp  = (idx + 1) % NB;
        cap_drop = deff;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // kind 0: real=k imag=-k; kind 1: random. gap 0: dense, 1: alternate, 2: random.
  task automatic send_frame(input int kind, input int gap, input int skip_at, input bit rand_ack);
    for (int k = 0; k < NB; k++) begin
      if (k == skip_at) continue;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 99) < 30)) begin
        bus.in_valid  = 1'b0;
        bus.note_done = rand_ack && ($urandom_range(0, 15) == 0);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_index = AW'(k);
      if (kind == 0) begin
        bus.in_real = DW'(k);
        bus.in_imag = -DW'(k);
      end else begin
        bus.in_real = DW'($urandom);
        bus.in_imag = DW'($urandom);
      end
      bus.note_done = rand_ack && ($urandom_range(0, 15) == 0);
      if (k == NB - 1) last_wr_cyc = cyc;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.note_done = 1'b0;
  endtask

  task automatic ack();
    bus.note_done = 1'b1;
    ack_cyc = cyc;
    tick();
    bus.note_done = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int budget, input string name);
    int n = 0;
    while (bursts < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bursts < target) begin
      errors++;
      $display("FAIL %s: timeout, bursts=%0d want %0d", name, bursts, target);
    end
  endtask

  initial begin
    int b0, d0, s0, n;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.note_done = 1'b0;
    repeat (3) tick();
    expect_eq("reset_fft_done", int'(bus.fft_done), 0);
    expect_eq("reset_read_valid", int'(bus.fft_read_valid), 0);
    expect_eq("reset_address", int'(bus.fft_address), 0);
    expect_eq("reset_real", int'(bus.data_in_real), 0);
    expect_eq("reset_imag", int'(bus.data_in_imag), 0);
    reset = 1'b0;
    tick();

    // Single frame k / -k
    b0 = bursts;
    lit_kk = 1'b1;
    send_frame(0, 0, -1, 1'b0);
    wait_bursts(b0 + 1, 2000, "s1_burst");
    lit_kk = 1'b0;
    expect_eq("s1_latency", first_done_cyc - last_wr_cyc, 3);
    expect_eq("s1_len", last_len, NB);
    expect_eq("s1_done_after", int'(bus.fft_done), 0);
    ack();

    // Back-to-back A, B; B held until note_done
    b0 = bursts;
    send_frame(1, 0, -1, 1'b0);
    send_frame(1, 0, -1, 1'b0);
    wait_bursts(b0 + 1, 2000, "s2_A");
    repeat (20) tick();
    expect_eq("s2_B_held", bursts, b0 + 1);
    expect_eq("s2_B_held_done", int'(bus.fft_done), 0);
    ack();
    wait_bursts(b0 + 2, 2000, "s2_B");
    expect_eq("s2_B_latency", first_done_cyc - ack_cyc, 3);
    expect_eq("s2_B_len", last_len, NB);
    ack();

    // A, B, C: C dropped
    b0 = bursts;
    d0 = drop_cnt;
    send_frame(1, 0, -1, 1'b0);
    send_frame(1, 0, -1, 1'b0);
    send_frame(1, 0, -1, 1'b0);
    expect_eq("s3_drop_pulses", drop_cnt - d0, 1);
    wait_bursts(b0 + 1, 2000, "s3_A");
    ack();
    wait_bursts(b0 + 2, 2000, "s3_B");
    ack();
    repeat (600) tick();
    expect_eq("s3_no_C", bursts, b0 + 2);

    // Index skip 0,1,2,4
    b0 = bursts;
    s0 = seq_cnt;
    d0 = drop_cnt;
    send_frame(1, 0, 3, 1'b0);
    expect_eq("s4_seq_pulses", seq_cnt - s0, 1);
    expect_eq("s4_drop_pulses", drop_cnt - d0, 1);
    repeat (10) tick();
    expect_eq("s4_no_burst", bursts, b0);
    send_frame(1, 0, -1, 1'b0);
    wait_bursts(b0 + 1, 2000, "s4_clean");
    expect_eq("s4_clean_len", last_len, NB);
    ack();

    // Sparse input
    b0 = bursts;
    send_frame(1, 1, -1, 1'b0);
    wait_bursts(b0 + 1, 2000, "s5_sparse");
    expect_eq("s5_len", last_len, NB);
    ack();

    // Reset mid-burst at address 200
    send_frame(1, 0, -1, 1'b0);
    n = 0;
    while (!(bus.fft_done && bus.fft_address == AW'(200)) && n < 2000) begin
      tick();
      n++;
    end
    expect_eq("s6_reached_200", int'(bus.fft_address), 200);
    reset = 1'b1;
    tick();
    expect_eq("s6_rst_done", int'(bus.fft_done), 0);
    expect_eq("s6_rst_valid", int'(bus.fft_read_valid), 0);
    expect_eq("s6_rst_addr", int'(bus.fft_address), 0);
    expect_eq("s6_rst_real", int'(bus.data_in_real), 0);
    expect_eq("s6_rst_imag", int'(bus.data_in_imag), 0);
    reset = 1'b0;
    tick();
    b0 = bursts;
    repeat (600) tick();
    expect_eq("s6_no_burst", bursts, b0);
    send_frame(1, 0, -1, 1'b0);
    wait_bursts(b0 + 1, 2000, "s6_new");
    expect_eq("s6_new_len", last_len, NB);
    ack();

    // Randomised traffic: gaps, stray acks, occasional index skips
    for (int f = 0; f < 6; f++) begin
      send_frame(1, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NB - 1)) : -1, 1'b1);
    end
    for (int i = 0; i < 1600; i++) begin
      bus.note_done = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.note_done = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
